eth_tx_arbiter: RTL and testbench

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter_pkg.sv | 20 ++
 rtl/eth_rr_pick.sv | 21 ++
 rtl/eth_tx_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arbiter_pkg.sv
// Shared ethernet definitions: buffer map, MTU, requester count
// and the TX arbiter state encoding.
package eth_tx_arbiter_pkg;

    localparam int ETHERNET_MTU = 1536;
    localparam logic [31:0] ETHERNET_TXBUF_BASE = 32'h0000_0000;
    localparam logic [31:0] ETHERNET_RXBUF_BASE = 32'h0000_0800;
    localparam logic [31:0] ETHERNET_REGS_BASE  = 32'h0000_1000;

    localparam int ETH_NREQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OWN,
        ST_SEND,
        ST_WAITTX,
        ST_REL
    } arb_state_t;

endpackage

// File: rtl/eth_rr_pick.sv
// Two-way round-robin selector: the pointed-at requester wins a
// tie, otherwise whichever requester is asserting is picked.
module eth_rr_pick
    import eth_tx_arbiter_pkg::*;
(
    input  logic [ETH_NREQ-1:0] req,
    input  logic                ptr,
    output logic [ETH_NREQ-1:0] pick
);

    // one-hot pick, mutually exclusive arms
    always_comb begin
        pick = '0;
        unique case (1'b1)
            req[1] && (ptr || !req[0]):  pick = 2'b10;
            req[0] && (!ptr || !req[1]): pick = 2'b01;
            default:                     pick = '0;
        endcase
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Two-requester TX buffer arbiter: grants the buffer, forwards byte
// writes, hands frames to the transmit engine, and revokes idle owners.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int MTU     = ETHERNET_MTU,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  wr,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic [1:0]  send,
    input  logic [15:0] len0,
    input  logic [15:0] len1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        buf_mw,
    output logic [31:0] buf_maddr,
    output logic [7:0]  buf_midata,
    output logic        tx_start,
    output logic [15:0] tx_size,
    input  logic        tx_busy
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
    localparam logic [31:0] MTU_U = 32'(MTU);

    arb_state_t state_q, state_d;

    logic [1:0]     gnt_d, done_d, err_d, pick;
    logic           mw_d, start_d;
    logic [31:0]    maddr_d;
    logic [7:0]     midata_d;
    logic [15:0]    size_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           ptr_q, ptr_d;
    logic           seen_q, seen_d;
    logic           lowc_q, lowc_d;

    logic           own, o_req, o_wr, o_send;
    logic [15:0]    o_addr, o_len;
    logic [7:0]     o_wdata;
    logic           addr_ok, len_ok, act, err_hit;

    eth_rr_pick u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick)
    );

    // route the current owner's strobes and operands
    always_comb begin
        own     = gnt[1];
        o_req   = own ? req[1]  : req[0];
        o_wr    = own ? wr[1]   : wr[0];
        o_send  = own ? send[1] : send[0];
        o_addr  = own ? addr1   : addr0;
        o_wdata = own ? wdata1  : wdata0;
        o_len   = own ? len1    : len0;
    end

    assign addr_ok = {16'h0, o_addr} < MTU_U;
    assign len_ok  = (o_len != 16'h0) && ({16'h0, o_len} <= MTU_U);
    assign act     = o_wr || o_send;

    // next state and next registered outputs
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt;
        done_d   = '0;
        err_d    = '0;
        mw_d     = 1'b0;
        maddr_d  = buf_maddr;
        midata_d = buf_midata;
        start_d  = 1'b0;
        size_d   = tx_size;
        wd_d     = wd_q;
        ptr_d    = ptr_q;
        seen_d   = seen_q;
        lowc_d   = lowc_q;
        err_hit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (|req) begin
                    gnt_d   = pick;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (o_wr) begin
                    if (addr_ok) begin
                        mw_d     = 1'b1;
                        maddr_d  = {16'h0, o_addr};
                        midata_d = o_wdata;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                if (o_send && !len_ok) begin
                    err_hit = 1'b1;
                end
                if (act) begin
                    wd_d = '0;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WDW'(1);
                end
                if (o_send && len_ok) begin
                    size_d  = o_len;
                    seen_d  = 1'b0;
                    lowc_d  = 1'b0;
                    state_d = ST_SEND;
                end else if (!o_req) begin
                    state_d = ST_REL;
                end else if (!act && wd_q == WD_MAX) begin
                    err_hit = 1'b1;
                    state_d = ST_REL;
                end
                if (err_hit) begin
                    err_d = gnt;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    start_d = 1'b1;
                    state_d = ST_WAITTX;
                end
            end
            ST_WAITTX: begin
                if (tx_busy) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    state_d = ST_REL;
                end else if (!tx_start) begin
                    if (lowc_q) begin
                        state_d = ST_REL;
                    end else begin
                        lowc_d = 1'b1;
                    end
                end
            end
            ST_REL: begin
                done_d  = gnt;
                gnt_d   = '0;
                ptr_d   = ~own;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, outputs and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            buf_mw     <= 1'b0;
            buf_maddr  <= '0;
            buf_midata <= '0;
            tx_start   <= 1'b0;
            tx_size    <= '0;
            wd_q       <= '0;
            ptr_q      <= 1'b0;
            seen_q     <= 1'b0;
            lowc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            done       <= done_d;
            err        <= err_d;
            buf_mw     <= mw_d;
            buf_maddr  <= maddr_d;
            buf_midata <= midata_d;
            tx_start   <= start_d;
            tx_size    <= size_d;
            wd_q       <= wd_d;
            ptr_q      <= ptr_d;
            seen_q     <= seen_d;
            lowc_q     <= lowc_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: directed scenarios followed by random
// frames checked against a frame-level reference model.
module tb_eth_tx_arbiter;

    localparam int MTU = 1536;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, wr, send;
    logic [15:0] addr0, addr1, len0, len1;
    logic [7:0]  wdata0, wdata1;
    logic [1:0]  gnt, done, err;
    logic        buf_mw;
    logic [31:0] buf_maddr;
    logic [7:0]  buf_midata;
    logic        tx_start;
    logic [15:0] tx_size;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;

    int cyc  = 0;
    int mw_n = 0;
    int mw_a [0:4095];
    int mw_d [0:4095];
    int mw_c [0:4095];
    int st_n = 0;
    int st_c = 0;
    int err_n  [2] = '{0, 0};
    int done_n [2] = '{0, 0};

    eth_tx_arbiter #(
        .MTU     (MTU),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .wr         (wr),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .send       (send),
        .len0       (len0),
        .len1       (len1),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .buf_mw     (buf_mw),
        .buf_maddr  (buf_maddr),
        .buf_midata (buf_midata),
        .tx_start   (tx_start),
        .tx_size    (tx_size),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    // log buffer writes and count pulses, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (buf_mw && mw_n < 4096) begin
            mw_a[mw_n] <= int'(buf_maddr);
            mw_d[mw_n] <= int'(buf_midata);
            mw_c[mw_n] <= cyc;
            mw_n       <= mw_n + 1;
        end
        if (tx_start) begin
            st_n <= st_n + 1;
            st_c <= cyc;
        end
        for (int i = 0; i < 2; i++) begin
            if (err[i])  err_n[i]  <= err_n[i] + 1;
            if (done[i]) done_n[i] <= done_n[i] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [1:0] oh(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input logic [1:0] exp, input string tag);
        int n;
        n = 0;
        while (gnt == 2'b00 && n < 10) begin
            step();
            n++;
        end
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    // k: engine busy cycles from send; m: busy cycles after tx_start
    task automatic wait_done(input int own, input int k, input int m,
                             input string tag);
        int n;
        int left;
        n = 0;
        left = k;
        while (done == 2'b00 && n < 400) begin
            step();
            n++;
            if (left > 0) left--;
            if (tx_start) left = m;
            tx_busy = (left > 0);
        end
        tx_busy = 1'b0;
        chk(tag, 32'({done, gnt}), 32'({oh(own), 2'b00}));
    endtask

    initial begin
        logic [7:0] d4 [4];
        int m0, s0, e0, e1, d0, n, ptr_m;
        d4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        rst_n = 1'b0;
        req = '0; wr = '0; send = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        len0 = '0; len1 = '0; tx_busy = 1'b0;
        step();
        step();
        chk("rst_ctl", 32'({gnt, done, err, buf_mw, tx_start}), 32'h0);
        chk("rst_maddr", buf_maddr, 32'h0);
        chk("rst_mid_size", 32'({buf_midata, tx_size}), 32'h0);

        rst_n = 1'b1;
        step();
        req = 2'b11;
        step();
        chk("gnt_first", 32'(gnt), 32'h1);

        m0 = mw_n; s0 = st_n;
        for (int i = 0; i < 4; i++) begin
            wr = 2'b01;
            addr0 = 16'(i);
            wdata0 = d4[i];
            if (i == 3) begin
                send = 2'b01;
                len0 = 16'd4;
            end
            step();
        end
        wr = '0; send = '0;
        wait_done(0, 0, 0, "done0");
        chk("frame_mw_cnt", 32'(mw_n - m0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("frame_mw_addr", 32'(mw_a[m0 + i]), 32'(i));
            chk("frame_mw_data", 32'(mw_d[m0 + i]), 32'(d4[i]));
        end
        chk("frame_start_cnt", 32'(st_n - s0), 32'd1);
        chk("frame_size", 32'(tx_size), 32'd4);
        chk("start_after_write", 32'(st_c > mw_c[m0 + 3]), 32'd1);
        wait_gnt(2'b10, "gnt_rr");

        m0 = mw_n; s0 = st_n; e0 = err_n[0]; e1 = err_n[1];
        wr = 2'b11;
        addr1 = 16'(MTU); wdata1 = 8'h55;
        addr0 = 16'd5; wdata0 = 8'h66;
        step();
        wr = '0;
        step();
        step();
        chk("bad_addr_err", 32'(err_n[1] - e1), 32'd1);
        chk("bad_addr_mw", 32'(mw_n - m0), 32'd0);
        chk("bad_addr_hold", 32'(gnt), 32'h2);
        chk("nonowner_err", 32'(err_n[0] - e0), 32'd0);
        send = 2'b10; len1 = 16'd0;
        step();
        send = '0;
        step();
        send = 2'b10; len1 = 16'(MTU + 1);
        step();
        send = '0;
        step();
        step();
        chk("bad_len_err", 32'(err_n[1] - e1), 32'd3);
        chk("bad_len_start", 32'(st_n - s0), 32'd0);
        chk("bad_len_hold", 32'(gnt), 32'h2);

        tx_busy = 1'b1;
        send = 2'b10; len1 = 16'(MTU);
        step();
        send = '0;
        repeat (19) step();
        chk("busy_no_start", 32'(st_n - s0), 32'd0);
        tx_busy = 1'b0;
        step();
        chk("start_after_busy", 32'(tx_start), 32'd1);
        wait_done(1, 0, 0, "done_busy");
        chk("busy_start_cnt", 32'(st_n - s0), 32'd1);
        chk("size_mtu", 32'(tx_size), 32'(MTU));

        wait_gnt(2'b01, "gnt_wd");
        e0 = err_n[0];
        n = 0;
        while (err == 2'b00 && n < 60) begin
            step();
            n++;
        end
        chk("wd_err", 32'(err), 32'h1);
        chk("wd_window", 32'((n >= TO) && (n <= TO + 3)), 32'd1);
        step();
        chk("wd_done", 32'({done, gnt}), 32'h4);
        wait_gnt(2'b10, "wd_next");

        s0 = st_n;
        req = 2'b00;
        wait_done(1, 0, 0, "rel_drop");
        chk("rel_drop_start", 32'(st_n - s0), 32'd0);

        req = 2'b01;
        wait_gnt(2'b01, "gnt_pre_rst");
        wr = 2'b01; addr0 = 16'd10; wdata0 = 8'h11;
        step();
        addr0 = 16'd11; wdata0 = 8'h22;
        step();
        wr = '0;
        d0 = done_n[0] + done_n[1];
        e0 = err_n[0] + err_n[1];
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", 32'({gnt, done, err, buf_mw, tx_start}), 32'h0);
        chk("arst_maddr", buf_maddr, 32'h0);
        chk("arst_mid_size", 32'({buf_midata, tx_size}), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        req = 2'b11;
        wait_gnt(2'b01, "rst_regrant");
        chk("rst_no_pulse", 32'((done_n[0] + done_n[1] - d0) +
                                (err_n[0] + err_n[1] - e0)), 32'd0);
        req = 2'b00;
        wait_done(0, 0, 0, "rst_rel");
        ptr_m = 1;

        for (int f = 0; f < 40; f++) begin
            logic [1:0]  rq;
            logic [15:0] a, ln;
            logic [7:0]  dd;
            int own, oth, nwr, nw, ne, eo, k, m, mode;
            int exp_a [8];
            int exp_d [8];
            rq = 2'($urandom_range(1, 3));
            own = (rq == 2'b11) ? ptr_m : (rq[1] ? 1 : 0);
            oth = 1 - own;
            req = rq;
            wait_gnt(oh(own), "rnd_gnt");
            m0 = mw_n; s0 = st_n;
            e0 = err_n[own]; eo = err_n[oth];
            nw = 0; ne = 0;
            nwr = $urandom_range(0, 6);
            for (int i = 0; i < nwr; i++) begin
                if ($urandom_range(0, 4) == 0)
                    a = 16'(MTU + $urandom_range(0, 100));
                else
                    a = 16'($urandom_range(0, MTU - 1));
                dd = 8'($urandom);
                wr = oh(own);
                if (own == 0) begin
                    addr0 = a; wdata0 = dd;
                end else begin
                    addr1 = a; wdata1 = dd;
                end
                if ($urandom_range(0, 1) == 1) begin
                    wr[oth] = 1'b1;
                    if (oth == 0) begin
                        addr0 = 16'($urandom); wdata0 = 8'($urandom);
                    end else begin
                        addr1 = 16'($urandom); wdata1 = 8'($urandom);
                    end
                end
                if (int'(a) < MTU) begin
                    exp_a[nw] = int'(a);
                    exp_d[nw] = int'(dd);
                    nw++;
                end else begin
                    ne++;
                end
                step();
                wr = '0;
                repeat ($urandom_range(0, 2)) step();
            end
            if ($urandom_range(0, 4) == 0) begin
                ln = ($urandom_range(0, 1) == 0) ? 16'd0
                   : 16'(MTU + $urandom_range(1, 500));
                send = oh(own);
                if (own == 0) len0 = ln; else len1 = ln;
                ne++;
                step();
                send = '0;
                step();
            end
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                req = 2'b00;
                wait_done(own, 0, 0, "rnd_done_drop");
                chk("rnd_drop_start", 32'(st_n - s0), 32'd0);
            end else begin
                ln = 16'($urandom_range(1, MTU));
                k = $urandom_range(0, 4);
                m = $urandom_range(0, 4);
                tx_busy = (k > 0);
                send = oh(own);
                if (own == 0) len0 = ln; else len1 = ln;
                step();
                send = '0;
                wait_done(own, k, m, "rnd_done_send");
                chk("rnd_start_cnt", 32'(st_n - s0), 32'd1);
                chk("rnd_size", 32'(tx_size), 32'(ln));
            end
            chk("rnd_mw_cnt", 32'(mw_n - m0), 32'(nw));
            for (int i = 0; i < nw; i++) begin
                chk("rnd_mw_addr", 32'(mw_a[m0 + i]), 32'(exp_a[i]));
                chk("rnd_mw_data", 32'(mw_d[m0 + i]), 32'(exp_d[i]));
            end
            chk("rnd_err_own", 32'(err_n[own] - e0), 32'(ne));
            chk("rnd_err_oth", 32'(err_n[oth] - eo), 32'd0);
            ptr_m = oth;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
